// File: rtl/stream_pkg.sv
// stream_pkg: defaults and counter-width helper shared by the pixel stream blocks.
package stream_pkg;
   localparam int DEFAULT_CHANNELS = 3;
   localparam int DEFAULT_ACTIVATION_WIDTH = 8;
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/channel_serializer_if.sv
// channel_serializer_if: valid/ready stream; the last flag exists only with CHANNEL_SERIALIZER_LAST_EN.
interface channel_serializer_if #(parameter int WIDTH = 8);
   logic valid;
   logic ready;
   logic [WIDTH-1:0] data;
`ifdef CHANNEL_SERIALIZER_LAST_EN
   logic last;
   modport master (output valid, data, last, input ready);
   modport slave (input valid, data, last, output ready);
`else
   modport master (output valid, data, input ready);
   modport slave (input valid, data, output ready);
`endif
endinterface

// File: rtl/wrap_counter.sv
// wrap_counter: counts enable pulses 0..MAX-1 then wraps; synchronous active-low reset.
module wrap_counter
   import stream_pkg::*;
#(
   parameter int MAX = 2
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic enable_i,
   output logic [clog2_min1(MAX)-1:0] count_o,
   output logic at_max_o
);
   localparam int W = clog2_min1(MAX);
   assign at_max_o = count_o == W'(MAX - 1);
   always_ff @(posedge clock_i)
      if (!reset_i) count_o <= '0;
      else if (enable_i) count_o <= at_max_o ? '0 : count_o + W'(1);
endmodule

// File: rtl/channel_serializer.sv
// channel_serializer: emits each packed pixel one activation per beat, channel 0 first.
// Define CHANNEL_SERIALIZER_LAST_EN to add the end-of-line last flag and its pixel counter.
module channel_serializer
   import stream_pkg::*;
#(
   parameter int CHANNELS = DEFAULT_CHANNELS,
   parameter int ACTIVATION_WIDTH = DEFAULT_ACTIVATION_WIDTH,
   parameter int LINE_PIXELS = 640
) (
   input logic clock_i,
   input logic reset_i,
   channel_serializer_if.slave pixel,
   channel_serializer_if.master beat
);
   localparam int CW = clog2_min1(CHANNELS);
   // Ascending outer range puts channel 0 in the most-significant slice.
   typedef logic [0:CHANNELS-1][ACTIVATION_WIDTH-1:0] pixel_t;
   pixel_t hold;
   logic loaded, chan_max, take, send, done;
   logic [CW-1:0] chan;
   assign beat.valid = reset_i && loaded;
   assign beat.data = hold[chan];
   assign pixel.ready = reset_i && (!loaded || (chan_max && beat.ready));
   assign take = pixel.valid && pixel.ready;
   assign send = beat.valid && beat.ready;
   assign done = send && chan_max;
   // chan is always 0 when a pixel is taken, so the counter never needs a load.
   wrap_counter #(.MAX(CHANNELS)) u_chan (
      .clock_i, .reset_i, .enable_i(send), .count_o(chan), .at_max_o(chan_max)
   );
   always_ff @(posedge clock_i)
      if (!reset_i) loaded <= 1'b0;
      else if (take) loaded <= 1'b1;
      else if (done) loaded <= 1'b0;
   always_ff @(posedge clock_i)
      if (take) hold <= pixel_t'(pixel.data);
`ifdef CHANNEL_SERIALIZER_LAST_EN
   logic [clog2_min1(LINE_PIXELS)-1:0] unused_pixel_count;
   logic line_end;
   wrap_counter #(.MAX(LINE_PIXELS)) u_pixel (
      .clock_i, .reset_i, .enable_i(done), .count_o(unused_pixel_count), .at_max_o(line_end)
   );
   assign beat.last = beat.valid && chan_max && line_end;
`endif
endmodule

// File: tb/tb_channel_serializer.sv
// tb_channel_serializer: directed and randomized checks of channel_serializer against a beat-queue model.
module tb_channel_serializer;
   localparam int LINE = 2;
   localparam int LINE1 = 3;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int vectors = 0;
   int miscompares = 0;
   always #5 clk = ~clk;
   channel_serializer_if #(.WIDTH(24)) pix3 ();
   channel_serializer_if #(.WIDTH(8)) out3 ();
   channel_serializer_if #(.WIDTH(8)) pix1 ();
   channel_serializer_if #(.WIDTH(8)) out1 ();
   channel_serializer #(.CHANNELS(3), .ACTIVATION_WIDTH(8), .LINE_PIXELS(LINE)) dut (
      .clock_i(clk), .reset_i(rst_n), .pixel(pix3), .beat(out3)
   );
   channel_serializer #(.CHANNELS(1), .ACTIVATION_WIDTH(8), .LINE_PIXELS(LINE1)) dut1 (
      .clock_i(clk), .reset_i(rst_n), .pixel(pix1), .beat(out1)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      pix3.valid = 1'b0;
      pix1.valid = 1'b0;
      out3.ready = 1'b0;
      out1.ready = 1'b0;
      tick;
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      pix3.valid = 1'b1;
      pix3.data = 24'hdeadbe;
      out3.ready = 1'b1;
      tick;
      @(negedge clk);
      vectors++;
      if (out3.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out3.valid); end
      vectors++;
      if (pix3.ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", pix3.ready); end
      vectors++;
      if (out1.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid1 got %b want 0", out1.valid); end
`ifdef CHANNEL_SERIALIZER_LAST_EN
      vectors++;
      if (out3.last !== 1'b0) begin miscompares++; $display("FAIL reset_last got %b want 0", out3.last); end
`endif
      tick;
      rst_n = 1'b1;
      pix3.valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (pix3.ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready got %b want 1", pix3.ready); end
      vectors++;
      if (out3.valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_valid got %b want 0", out3.valid); end
      tick;
   endtask

   task automatic test_basic;
      logic [23:0] px;
      px = 24'h112233;
      pix3.valid = 1'b1;
      pix3.data = px;
      out3.ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (pix3.ready !== 1'b1) begin miscompares++; $display("FAIL basic_accept got %b want 1", pix3.ready); end
      tick;
      pix3.valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if ({out3.valid, out3.data} !== {1'b1, px[23-8*i -: 8]}) begin
            miscompares++;
            $display("FAIL basic_beat%0d got v=%b d=%h want v=1 d=%h", i, out3.valid, out3.data, px[23-8*i -: 8]);
         end
         vectors++;
         if (pix3.ready !== (i == 2)) begin miscompares++; $display("FAIL basic_ready%0d got %b want %b", i, pix3.ready, i == 2); end
         tick;
      end
      @(negedge clk);
      vectors++;
      if (out3.valid !== 1'b0) begin miscompares++; $display("FAIL basic_idle got %b want 0", out3.valid); end
      tick;
   endtask

   task automatic test_streaming;
      logic [23:0] px [2];
      px[0] = 24'h010203;
      px[1] = 24'h040506;
      pix3.valid = 1'b1;
      pix3.data = px[0];
      out3.ready = 1'b1;
      tick;
      pix3.data = px[1];
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         vectors++;
         if ({out3.valid, out3.data} !== {1'b1, px[k/3][23-8*(k%3) -: 8]}) begin
            miscompares++;
            $display("FAIL stream_beat%0d got v=%b d=%h want v=1 d=%h", k, out3.valid, out3.data, px[k/3][23-8*(k%3) -: 8]);
         end
         if (k < 3) begin
            vectors++;
            if (pix3.ready !== (k == 2)) begin miscompares++; $display("FAIL stream_ready%0d got %b want %b", k, pix3.ready, k == 2); end
         end
         tick;
         if (k == 2) pix3.valid = 1'b0;
      end
      @(negedge clk);
      vectors++;
      if (out3.valid !== 1'b0) begin miscompares++; $display("FAIL stream_idle got %b want 0", out3.valid); end
      tick;
   endtask

   task automatic test_backpressure;
      logic [7:0] want [3];
      want[0] = 8'h11;
      want[1] = 8'h22;
      want[2] = 8'h33;
      pix3.valid = 1'b1;
      pix3.data = 24'h112233;
      out3.ready = 1'b1;
      tick;
      pix3.valid = 1'b0;
      @(negedge clk);
      vectors++;
      if ({out3.valid, out3.data} !== {1'b1, want[0]}) begin miscompares++; $display("FAIL bp_first got v=%b d=%h want v=1 d=11", out3.valid, out3.data); end
      tick;
      out3.ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         vectors++;
         if ({out3.valid, out3.data} !== {1'b1, want[1]}) begin miscompares++; $display("FAIL bp_hold%0d got v=%b d=%h want v=1 d=22", c, out3.valid, out3.data); end
         tick;
      end
      out3.ready = 1'b1;
      for (int i = 1; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if ({out3.valid, out3.data} !== {1'b1, want[i]}) begin miscompares++; $display("FAIL bp_resume%0d got v=%b d=%h want v=1 d=%h", i, out3.valid, out3.data, want[i]); end
         tick;
      end
      @(negedge clk);
      vectors++;
      if (out3.valid !== 1'b0) begin miscompares++; $display("FAIL bp_idle got %b want 0", out3.valid); end
      tick;
   endtask

   task automatic test_reset_mid;
      logic [23:0] px;
      pix3.valid = 1'b1;
      pix3.data = 24'h112233;
      out3.ready = 1'b1;
      tick;
      pix3.valid = 1'b0;
      @(negedge clk);
      vectors++;
      if ({out3.valid, out3.data} !== 9'h111) begin miscompares++; $display("FAIL rstmid_first got v=%b d=%h want v=1 d=11", out3.valid, out3.data); end
      tick;
      rst_n = 1'b0;
      @(negedge clk);
      vectors++;
      if (out3.valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid got %b want 0", out3.valid); end
      tick;
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (out3.valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_after got %b want 0", out3.valid); end
      tick;
      px = 24'haabbcc;
      pix3.valid = 1'b1;
      pix3.data = px;
      tick;
      pix3.valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if ({out3.valid, out3.data} !== {1'b1, px[23-8*i -: 8]}) begin
            miscompares++;
            $display("FAIL rstmid_beat%0d got v=%b d=%h want v=1 d=%h", i, out3.valid, out3.data, px[23-8*i -: 8]);
         end
         tick;
      end
      @(negedge clk);
      vectors++;
      if (out3.valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle got %b want 0", out3.valid); end
      tick;
   endtask

`ifdef CHANNEL_SERIALIZER_LAST_EN
   task automatic test_last;
      int k;
      int taken;
      logic want;
      k = 0;
      taken = 0;
      do_reset;
      out3.ready = 1'b1;
      pix3.valid = 1'b1;
      pix3.data = 24'($urandom);
      for (int c = 0; c < 14 && k < 9; c++) begin
         @(negedge clk);
         if (pix3.valid && pix3.ready) taken++;
         if (out3.valid) begin
            want = (k % 3 == 2) && ((k / 3) % LINE == LINE - 1);
            vectors++;
            if (out3.last !== want) begin miscompares++; $display("FAIL last_beat%0d got %b want %b", k, out3.last, want); end
            k++;
         end
         tick;
         if (taken >= 3) pix3.valid = 1'b0;
         else pix3.data = 24'($urandom);
      end
      vectors++;
      if (k != 9) begin miscompares++; $display("FAIL last_count got %0d beats want 9", k); end
   endtask
`endif

   task automatic test_random;
      logic [7:0] q [$];
      int pixels;
      int beats;
      logic stall;
      logic [7:0] held;
      pixels = 0;
      beats = 0;
      stall = 1'b0;
      held = '0;
      do_reset;
      for (int c = 0; c < 5000 && (pixels < 200 || q.size() != 0); c++) begin
         pix3.valid = (pixels < 200) && 1'($urandom_range(0, 1));
         pix3.data = 24'($urandom);
         out3.ready = (pixels >= 200) || 1'($urandom_range(0, 1));
         @(negedge clk);
         if (stall) begin
            vectors++;
            if ({out3.valid, out3.data} !== {1'b1, held}) begin miscompares++; $display("FAIL rand_hold got v=%b d=%h want v=1 d=%h", out3.valid, out3.data, held); end
         end
         if (out3.valid) begin
            vectors++;
            if (q.size() == 0) begin miscompares++; $display("FAIL rand_extra got beat %h want none", out3.data); end
            else if (out3.data !== q[0]) begin miscompares++; $display("FAIL rand_data beat %0d got %h want %h", beats, out3.data, q[0]); end
`ifdef CHANNEL_SERIALIZER_LAST_EN
            vectors++;
            if (out3.last !== ((beats % 3 == 2) && ((beats / 3) % LINE == LINE - 1))) begin
               miscompares++;
               $display("FAIL rand_last beat %0d got %b", beats, out3.last);
            end
`endif
            if (out3.ready) begin
               if (q.size() != 0) void'(q.pop_front());
               beats++;
            end
         end
         stall = out3.valid && !out3.ready;
         held = out3.data;
         if (pix3.valid && pix3.ready) begin
            for (int i = 0; i < 3; i++) q.push_back(pix3.data[23-8*i -: 8]);
            pixels++;
         end
         tick;
      end
      vectors++;
      if (pixels != 200 || q.size() != 0) begin miscompares++; $display("FAIL rand_drain got %0d pixels %0d pending want 200 and 0", pixels, q.size()); end
      pix3.valid = 1'b0;
   endtask

   task automatic test_degenerate;
      logic [7:0] q [$];
      int pixels;
      int beats;
      logic stall;
      logic [7:0] held;
      pixels = 0;
      beats = 0;
      stall = 1'b0;
      held = '0;
      do_reset;
      for (int c = 0; c < 20000 && (pixels < 1000 || q.size() != 0); c++) begin
         pix1.valid = (pixels < 1000) && 1'($urandom_range(0, 1));
         pix1.data = 8'($urandom);
         out1.ready = (pixels >= 1000) || 1'($urandom_range(0, 1));
         @(negedge clk);
         if (stall) begin
            vectors++;
            if ({out1.valid, out1.data} !== {1'b1, held}) begin miscompares++; $display("FAIL deg_hold got v=%b d=%h want v=1 d=%h", out1.valid, out1.data, held); end
         end
         if (out1.valid) begin
            vectors++;
            if (q.size() == 0) begin miscompares++; $display("FAIL deg_extra got beat %h want none", out1.data); end
            else if (out1.data !== q[0]) begin miscompares++; $display("FAIL deg_data beat %0d got %h want %h", beats, out1.data, q[0]); end
`ifdef CHANNEL_SERIALIZER_LAST_EN
            vectors++;
            if (out1.last !== (beats % LINE1 == LINE1 - 1)) begin miscompares++; $display("FAIL deg_last beat %0d got %b", beats, out1.last); end
`endif
            if (out1.ready) begin
               if (q.size() != 0) void'(q.pop_front());
               beats++;
            end
         end
         stall = out1.valid && !out1.ready;
         held = out1.data;
         if (pix1.valid && pix1.ready) begin
            q.push_back(pix1.data);
            pixels++;
         end
         tick;
      end
      vectors++;
      if (pixels != 1000 || q.size() != 0) begin miscompares++; $display("FAIL deg_drain got %0d pixels %0d pending want 1000 and 0", pixels, q.size()); end
      pix1.valid = 1'b0;
   endtask

   initial begin
      pix3.valid = 1'b0;
      pix3.data = '0;
      pix1.valid = 1'b0;
      pix1.data = '0;
      out3.ready = 1'b0;
      out1.ready = 1'b0;
`ifdef CHANNEL_SERIALIZER_LAST_EN
      pix3.last = 1'b0;
      pix1.last = 1'b0;
`endif
      test_reset;
      test_basic;
      test_streaming;
      test_backpressure;
      test_reset_mid;
`ifdef CHANNEL_SERIALIZER_LAST_EN
      test_last;
`endif
      test_random;
      test_degenerate;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
